usb_packet_arbiter: RTL and testbench

Shares the single packet input of usb_comm between two packet sources. The first is the RAM trace state machine, a strobe-only source with no backpressure. The second is an auxiliary source such as status, configuration echo or oscillator reports, which uses a valid/ready handshake. Trace packets are buffered in a small FIFO and have priority, with a starvation guard for the auxiliary source. Output slots are paced to a configurable minimum gap. Trace drops are counted and flagged.

---
 rtl/usb_packet_arbiter.sv | 110 +++++++++++
 tb/tb_usb_packet_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_packet_arbiter.sv
// Arbitrates usb_comm's single packet input between a strobe-only trace source (FIFO-buffered)
// and a valid/ready auxiliary source, with a starvation guard, output pacing and drop accounting.
module usb_packet_arbiter #(
    parameter int FIFO_AW    = 3,
    parameter int MIN_GAP    = 1,
    parameter int AUX_STARVE = 16
) (
    input  logic               mclk,
    input  logic               reset,
    input  logic [1:0]         trace_type,
    input  logic [22:0]        trace_payload,
    input  logic               trace_strobe,
    input  logic [1:0]         aux_type,
    input  logic [22:0]        aux_payload,
    input  logic               aux_valid,
    output logic               aux_ready,
    output logic [1:0]         out_type,
    output logic [22:0]        out_payload,
    output logic               out_strobe,
    input  logic               ovf_clear,
    output logic               overflow,
    output logic [15:0]        drop_count,
    output logic [FIFO_AW:0]   fifo_level
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef struct packed {
        logic [1:0]  ptype;
        logic [22:0] payload;
    } pkt_t;

    typedef enum logic [1:0] {GRANT_NONE, GRANT_TRACE, GRANT_AUX} grant_e;

    pkt_t               mem [DEPTH];
    pkt_t               out_pkt;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level;
    logic [7:0]         gap_cnt;
    logic [7:0]         starve_cnt;
    grant_e             grant;
    logic               full;
    logic               empty;
    logic               wr_en;
    logic               rd_en;
    logic               drop;

    assign full       = (level == (FIFO_AW+1)'(DEPTH));
    assign empty      = (level == '0);
    assign wr_en      = trace_strobe && !full;
    assign drop       = trace_strobe && full;
    assign rd_en      = (grant == GRANT_TRACE);
    assign aux_ready  = (grant == GRANT_AUX);
    assign fifo_level = level;
    assign out_type    = out_pkt.ptype;
    assign out_payload = out_pkt.payload;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant = GRANT_NONE;
        if (gap_cnt == 8'd0) begin
            if (aux_valid && starve_cnt >= 8'(AUX_STARVE)) grant = GRANT_AUX;
            else if (!empty)                               grant = GRANT_TRACE;
            else if (aux_valid)                            grant = GRANT_AUX;
        end
    end

    // NOTE: packet storage has no reset; validity is tracked by the pointers and level alone.
    always_ff @(posedge mclk) begin
        if (wr_en) mem[wr_ptr] <= '{ptype: trace_type, payload: trace_payload};
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            gap_cnt    <= '0;
            starve_cnt <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            out_strobe <= 1'b0;
            out_pkt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (FIFO_AW+1)'(wr_en) - (FIFO_AW+1)'(rd_en);

            // A drop in the same cycle as a clear restarts the count at one.
            if (drop) begin
                overflow <= 1'b1;
                if (ovf_clear)                  drop_count <= 16'd1;
                else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end else if (ovf_clear) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end

            if (grant != GRANT_NONE) gap_cnt <= 8'(MIN_GAP - 1);
            else if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;

            if (!aux_valid || grant == GRANT_AUX) starve_cnt <= '0;
            else if (starve_cnt != 8'hFF)         starve_cnt <= starve_cnt + 8'd1;

            out_strobe <= (grant != GRANT_NONE);
            if (grant == GRANT_TRACE)    out_pkt <= mem[rd_ptr];
            else if (grant == GRANT_AUX) out_pkt <= '{ptype: aux_type, payload: aux_payload};
        end
    end
endmodule

// File: tb/tb_usb_packet_arbiter.sv
// Directed bench for usb_packet_arbiter: three instances (MIN_GAP 1, 4, 255) share one stimulus stream.
module tb_usb_packet_arbiter;
    logic        mclk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  trace_type = '0;
    logic [22:0] trace_payload = '0;
    logic        trace_strobe = 1'b0;
    logic [1:0]  aux_type = '0;
    logic [22:0] aux_payload = '0;
    logic        aux_valid = 1'b0;
    logic        ovf_clear = 1'b0;

    logic        g1_aux_ready, g1_out_strobe, g1_overflow;
    logic [1:0]  g1_out_type;
    logic [22:0] g1_out_payload;
    logic [15:0] g1_drop_count;
    logic [3:0]  g1_fifo_level;
    logic        g4_aux_ready, g4_out_strobe, g4_overflow;
    logic [1:0]  g4_out_type;
    logic [22:0] g4_out_payload;
    logic [15:0] g4_drop_count;
    logic [3:0]  g4_fifo_level;
    logic        gs_aux_ready, gs_out_strobe, gs_overflow;
    logic [1:0]  gs_out_type;
    logic [22:0] gs_out_payload;
    logic [15:0] gs_drop_count;
    logic [3:0]  gs_fifo_level;

    int checks = 0;
    int failures = 0;

    always #5 mclk = ~mclk;

    usb_packet_arbiter #(.FIFO_AW(3), .MIN_GAP(1), .AUX_STARVE(16)) u_g1 (
        .mclk(mclk), .reset(reset), .trace_type(trace_type), .trace_payload(trace_payload),
        .trace_strobe(trace_strobe), .aux_type(aux_type), .aux_payload(aux_payload),
        .aux_valid(aux_valid), .aux_ready(g1_aux_ready), .out_type(g1_out_type),
        .out_payload(g1_out_payload), .out_strobe(g1_out_strobe), .ovf_clear(ovf_clear),
        .overflow(g1_overflow), .drop_count(g1_drop_count), .fifo_level(g1_fifo_level));

    usb_packet_arbiter #(.FIFO_AW(3), .MIN_GAP(4), .AUX_STARVE(16)) u_g4 (
        .mclk(mclk), .reset(reset), .trace_type(trace_type), .trace_payload(trace_payload),
        .trace_strobe(trace_strobe), .aux_type(aux_type), .aux_payload(aux_payload),
        .aux_valid(aux_valid), .aux_ready(g4_aux_ready), .out_type(g4_out_type),
        .out_payload(g4_out_payload), .out_strobe(g4_out_strobe), .ovf_clear(ovf_clear),
        .overflow(g4_overflow), .drop_count(g4_drop_count), .fifo_level(g4_fifo_level));

    usb_packet_arbiter #(.FIFO_AW(3), .MIN_GAP(255), .AUX_STARVE(16)) u_gs (
        .mclk(mclk), .reset(reset), .trace_type(trace_type), .trace_payload(trace_payload),
        .trace_strobe(trace_strobe), .aux_type(aux_type), .aux_payload(aux_payload),
        .aux_valid(aux_valid), .aux_ready(gs_aux_ready), .out_type(gs_out_type),
        .out_payload(gs_out_payload), .out_strobe(gs_out_strobe), .ovf_clear(ovf_clear),
        .overflow(gs_overflow), .drop_count(gs_drop_count), .fifo_level(gs_fifo_level));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic do_reset();
        trace_strobe = 1'b0;
        aux_valid    = 1'b0;
        ovf_clear    = 1'b0;
        reset        = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int exp_n;
        int tn;
        int aux_seen;

        // Reset state
        do_reset();
        check("rst_level", 32'(g1_fifo_level), 32'd0);
        check("rst_strobe", 32'(g1_out_strobe), 32'd0);
        check("rst_type", 32'(g1_out_type), 32'd0);
        check("rst_payload", 32'(g1_out_payload), 32'd0);
        check("rst_aux_ready", 32'(g1_aux_ready), 32'd0);
        check("rst_overflow", 32'(g1_overflow), 32'd0);
        check("rst_drop_count", 32'(g1_drop_count), 32'd0);

        // Single trace packet: out_strobe two cycles after the strobe
        trace_strobe = 1'b1; trace_type = 2'b00; trace_payload = 23'h12345;
        tick();
        trace_strobe = 1'b0;
        check("lat_t1_level", 32'(g1_fifo_level), 32'd1);
        check("lat_t1_strobe", 32'(g1_out_strobe), 32'd0);
        tick();
        check("lat_t2_strobe", 32'(g1_out_strobe), 32'd1);
        check("lat_t2_type", 32'(g1_out_type), 32'd0);
        check("lat_t2_payload", 32'(g1_out_payload), 32'h12345);
        check("lat_t2_level", 32'(g1_fifo_level), 32'd0);
        tick();
        check("lat_t3_strobe", 32'(g1_out_strobe), 32'd0);
        repeat (10) tick();

        // Aux with empty FIFO: ready same cycle, output next cycle
        aux_valid = 1'b1; aux_type = 2'b11; aux_payload = 23'h7FFFFF;
        #1;
        check("aux_ready_g1", 32'(g1_aux_ready), 32'd1);
        check("aux_ready_g4", 32'(g4_aux_ready), 32'd1);
        tick();
        check("aux_out_strobe", 32'(g1_out_strobe), 32'd1);
        check("aux_out_type", 32'(g1_out_type), 32'd3);
        check("aux_out_payload", 32'(g1_out_payload), 32'h7FFFFF);
        aux_valid = 1'b0;
        #1;
        check("aux_ready_after", 32'(g1_aux_ready), 32'd0);
        tick();
        check("aux_strobe_after", 32'(g1_out_strobe), 32'd0);
        check("aux_payload_hold", 32'(g1_out_payload), 32'h7FFFFF);

        // 13 back-to-back strobes into MIN_GAP=4; drop at c11, drop+clear at c12, clear at c13
        do_reset();
        exp_n = 0;
        for (int c = 0; c < 60; c++) begin
            trace_strobe  = (c <= 12);
            trace_type    = 2'b00;
            trace_payload = 23'(c);
            ovf_clear     = (c == 12 || c == 13);
            tick();
            if (g4_out_strobe) begin
                check("gap_order", 32'(g4_out_payload), 32'(exp_n));
                check("gap_spacing", 32'(c + 1), 32'(2 + 4 * exp_n));
                exp_n++;
            end
            if (c == 11) begin
                check("drop1_ovf", 32'(g4_overflow), 32'd1);
                check("drop1_cnt", 32'(g4_drop_count), 32'd1);
                check("gs_drop3_cnt", 32'(gs_drop_count), 32'd3);
            end
            if (c == 12) begin
                check("clr_drop_ovf", 32'(g4_overflow), 32'd1);
                check("clr_drop_cnt", 32'(g4_drop_count), 32'd1);
                check("gs_clr_drop_cnt", 32'(gs_drop_count), 32'd1);
            end
            if (c == 13) begin
                check("clr_ovf", 32'(g4_overflow), 32'd0);
                check("clr_cnt", 32'(g4_drop_count), 32'd0);
                check("gs_clr_ovf", 32'(gs_overflow), 32'd0);
                check("gs_clr_cnt", 32'(gs_drop_count), 32'd0);
            end
        end
        trace_strobe = 1'b0;
        ovf_clear    = 1'b0;
        check("gap_out_count", 32'(exp_n), 32'd11);
        check("gap_drained", 32'(g4_fifo_level), 32'd0);

        // Starvation: continuous trace, aux waits from s2, granted at s18 (17th waiting cycle)
        do_reset();
        tn = 0;
        aux_seen = 0;
        aux_type = 2'b01;
        aux_payload = 23'h0055AA;
        for (int s = 0; s < 40; s++) begin
            trace_strobe  = (s < 30);
            trace_type    = 2'b00;
            trace_payload = 23'(100 + s);
            aux_valid     = (s >= 2 && s <= 18);
            #1;
            if (aux_valid) check("starve_ready", 32'(g1_aux_ready), 32'(s == 18));
            tick();
            if (g1_out_strobe) begin
                if (g1_out_type == 2'b01) begin
                    check("starve_aux_payload", 32'(g1_out_payload), 32'h55AA);
                    check("starve_aux_cycle", 32'(s + 1), 32'd19);
                    aux_seen++;
                end else begin
                    check("starve_trace_order", 32'(g1_out_payload), 32'(100 + tn));
                    tn++;
                end
            end
        end
        check("starve_trace_count", 32'(tn), 32'd30);
        check("starve_aux_count", 32'(aux_seen), 32'd1);
        check("starve_no_overflow", 32'(g1_overflow), 32'd0);

        // Reset with packets queued discards them
        do_reset();
        for (int c = 0; c < 6; c++) begin
            trace_strobe  = 1'b1;
            trace_payload = 23'(200 + c);
            tick();
        end
        trace_strobe = 1'b0;
        check("mid_gs_level", 32'(gs_fifo_level), 32'd5);
        check("mid_g4_level", 32'(g4_fifo_level), 32'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_gs_level", 32'(gs_fifo_level), 32'd0);
        check("mid_rst_g4_level", 32'(g4_fifo_level), 32'd0);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("mid_gs_quiet", 32'(gs_out_strobe), 32'd0);
            check("mid_g4_quiet", 32'(g4_out_strobe), 32'd0);
        end
        check("mid_gs_level_end", 32'(gs_fifo_level), 32'd0);

        // Sustained overflow on MIN_GAP=255 saturates drop_count
        do_reset();
        trace_strobe = 1'b1;
        repeat (66000) tick();
        check("sat_cnt", 32'(gs_drop_count), 32'hFFFF);
        check("sat_ovf", 32'(gs_overflow), 32'd1);
        repeat (300) tick();
        check("sat_hold", 32'(gs_drop_count), 32'hFFFF);
        trace_strobe = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
